// File: rtl/cplx_pipe_scheduler.sv
// Round-robin scheduler sharing one fixed-latency complex pipeline between NREQ requesters.
// Latency: grant in T, p_issue in T+1, routed response in T+1+LAT; no response backpressure.
// Optional build macro CPLX_SCHED_SERIAL_EN limits the pipeline to a single operation in flight.
module cplx_pipe_scheduler #(
    parameter int pd   = 12,
    parameter int p    = 22,
    parameter int NREQ = 2,
    parameter int LAT  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*(pd+p)-1:0]   req_d0,
    input  logic [NREQ*(pd+p)-1:0]   req_d1,
    input  logic [NREQ*(pd+p)-1:0]   req_d2,
    output logic                     p_issue,
    output logic [pd+p-1:0]          p_d0,
    output logic [pd+p-1:0]          p_d1,
    output logic [pd+p-1:0]          p_d2,
    input  logic [pd+p-1:0]          p_r0,
    input  logic [pd+p-1:0]          p_r1,
    input  logic [pd+p-1:0]          p_r2,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [pd+p-1:0]          rsp_d0,
    output logic [pd+p-1:0]          rsp_d1,
    output logic [pd+p-1:0]          rsp_d2,
    output logic [$clog2(LAT+2)-1:0] inflight,
    output logic                     busy
);
    localparam int W   = pd + p;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IFW = $clog2(LAT + 2);
    localparam logic [IDW:0]   NREQ_C = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0]    ptr;
    logic [2*NREQ-1:0] rot_wide;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;
    logic              any_vld;
    logic [IDW-1:0]    gnt_id;
    logic              eligible;
    logic              grant;
    logic [W-1:0]      mux_d0, mux_d1, mux_d2;

    logic [LAT:0]      tag_vld;
    logic [IDW-1:0]    tag_id [0:LAT];
    logic              ret_vld;
    logic [IDW-1:0]    ret_id;

    assign ret_vld = tag_vld[LAT];
    assign ret_id  = tag_id[LAT];

`ifdef CPLX_SCHED_SERIAL_EN
    // A returning tag frees the only slot in the same cycle, so the next grant can overlap it.
    assign eligible = (inflight == '0) || ((inflight == IFW'(1)) && ret_vld);
`else
    assign eligible = 1'b1;
`endif

    always_comb begin
        rot_wide = {req_valid, req_valid} >> ptr;
        rot      = rot_wide[NREQ-1:0];
        any_vld  = |rot;
        off      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IDW'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NREQ_C) sum = sum - NREQ_C;
        gnt_id = sum[IDW-1:0];
        grant  = any_vld & eligible & ~rst;

        req_ready = '0;
        if (grant) req_ready[gnt_id] = 1'b1;

        mux_d0 = '0;
        mux_d1 = '0;
        mux_d2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                mux_d0 = req_d0[i*W +: W];
                mux_d1 = req_d1[i*W +: W];
                mux_d2 = req_d2[i*W +: W];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (ret_vld) rsp_valid[ret_id] = 1'b1;
        rsp_d0 = ret_vld ? p_r0 : '0;
        rsp_d1 = ret_vld ? p_r1 : '0;
        rsp_d2 = ret_vld ? p_r2 : '0;
    end

    assign busy = (inflight != '0) | (|req_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            p_issue  <= 1'b0;
            p_d0     <= '0;
            p_d1     <= '0;
            p_d2     <= '0;
            tag_vld  <= '0;
            inflight <= '0;
            for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
        end else begin
            p_issue <= grant;
            p_d0    <= grant ? mux_d0 : '0;
            p_d1    <= grant ? mux_d1 : '0;
            p_d2    <= grant ? mux_d2 : '0;
            tag_vld <= {tag_vld[LAT-1:0], grant};
            tag_id[0] <= gnt_id;
            for (int s = 1; s <= LAT; s++) tag_id[s] <= tag_id[s-1];
            if (grant) ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            case ({grant, ret_vld})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_cplx_pipe_scheduler.sv
// Bench for cplx_pipe_scheduler: pipeline model, round-robin scoreboard, directed steps.
module tb_cplx_pipe_scheduler;
    localparam int PD   = 12;
    localparam int P    = 22;
    localparam int NREQ = 2;
    localparam int LAT  = 6;
    localparam int W    = PD + P;
    localparam int IFW  = $clog2(LAT + 2);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_d0 = '0, req_d1 = '0, req_d2 = '0;
    logic              p_issue;
    logic [W-1:0]      p_d0, p_d1, p_d2, p_r0, p_r1, p_r2;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_d0, rsp_d1, rsp_d2;
    logic [IFW-1:0]    inflight;
    logic              busy;

    int n_chk = 0, n_fail = 0, cyc = 0, max_if = 0;
    logic         force_en = 1'b0;
    logic [W-1:0] force_val = '0;
    logic [W-1:0] pipe0 [LAT];
    logic [W-1:0] pipe1 [LAT];
    logic [W-1:0] pipe2 [LAT];

    cplx_pipe_scheduler #(.pd(PD), .p(P), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_d0(req_d0), .req_d1(req_d1), .req_d2(req_d2),
        .p_issue(p_issue), .p_d0(p_d0), .p_d1(p_d1), .p_d2(p_d2),
        .p_r0(p_r0), .p_r1(p_r1), .p_r2(p_r2),
        .rsp_valid(rsp_valid), .rsp_d0(rsp_d0), .rsp_d1(rsp_d1), .rsp_d2(rsp_d2),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pipeline model: results appear LAT cycles after p_d*, never reset.
    always @(posedge clk) begin
        for (int s = LAT - 1; s > 0; s--) begin
            pipe0[s] <= pipe0[s-1];
            pipe1[s] <= pipe1[s-1];
            pipe2[s] <= pipe2[s-1];
        end
        pipe0[0] <= p_d0;
        pipe1[0] <= p_d1;
        pipe2[0] <= p_d2;
    end
    assign p_r0 = force_en ? force_val : pipe0[LAT-1] + W'(1);
    assign p_r1 = pipe1[LAT-1] ^ 34'h2_AAAA_5555;
    assign p_r2 = pipe0[LAT-1] + pipe2[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] r0, r1, r2;
    } exp_t;
    exp_t sb[$];

    int           m_ptr = 0, m_nif, m_g;
    bit           m_ret, m_elig;
    logic         e_iss = 1'b0;
    logic [W-1:0] e_pd0 = '0, e_pd1 = '0, e_pd2 = '0;
    logic [W-1:0] x0, x1, x2;
    logic [63:0]  e_rv, e_rdy;

    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_reset", 64'(req_ready), 64'(0));
            sb.delete();
            m_ptr = 0;
            e_iss = 1'b0;
            e_pd0 = '0; e_pd1 = '0; e_pd2 = '0;
        end else begin
            check("p_issue", 64'(p_issue), 64'(e_iss));
            check("p_d0", 64'(p_d0), 64'(e_pd0));
            check("p_d1", 64'(p_d1), 64'(e_pd1));
            check("p_d2", 64'(p_d2), 64'(e_pd2));
            m_nif = sb.size();
            check("inflight", 64'(inflight), 64'(m_nif));
            check("busy", 64'(busy), 64'((m_nif != 0) || (req_valid != '0)));
            if (int'(inflight) > max_if) max_if = int'(inflight);

            m_ret = (m_nif > 0) && (sb[0].due == cyc);
            e_rv  = m_ret ? (64'(1) << sb[0].id) : 64'(0);
            check("rsp_valid", 64'(rsp_valid), e_rv);
            check("rsp_d0", 64'(rsp_d0), m_ret ? 64'(sb[0].r0) : 64'(0));
            check("rsp_d1", 64'(rsp_d1), m_ret ? 64'(sb[0].r1) : 64'(0));
            check("rsp_d2", 64'(rsp_d2), m_ret ? 64'(sb[0].r2) : 64'(0));
            if (m_ret) void'(sb.pop_front());
`ifdef CPLX_SCHED_SERIAL_EN
            m_elig = (m_nif == 0) || (m_nif == 1 && m_ret);
`else
            m_elig = 1'b1;
`endif
            m_g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
            end
            if (!m_elig) m_g = -1;
            e_rdy = (m_g >= 0) ? (64'(1) << m_g) : 64'(0);
            check("req_ready", 64'(req_ready), e_rdy);
            if (m_g >= 0) begin
                x0 = req_d0[m_g*W +: W];
                x1 = req_d1[m_g*W +: W];
                x2 = req_d2[m_g*W +: W];
                sb.push_back('{due: cyc + 1 + LAT, id: m_g,
                               r0: x0 + W'(1), r1: x1 ^ 34'h2_AAAA_5555, r2: x0 + x2});
                m_ptr = (m_g + 1) % NREQ;
                e_iss = 1'b1;
                e_pd0 = x0; e_pd1 = x1; e_pd2 = x2;
            end else begin
                e_iss = 1'b0;
                e_pd0 = '0; e_pd1 = '0; e_pd2 = '0;
            end
        end
    end

    function automatic logic [W-1:0] rnd_w();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NREQ-1:0] v);
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_d0[i*W +: W] = rnd_w();
            req_d1[i*W +: W] = rnd_w();
            req_d2[i*W +: W] = rnd_w();
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_p_issue", 64'(p_issue), 64'(0));
        check("post_rst_p_d0", 64'(p_d0), 64'(0));
        check("post_rst_inflight", 64'(inflight), 64'(0));
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("post_rst_rsp_d0", 64'(rsp_d0), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));
    endtask

    logic [NREQ-1:0] exp2;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_p_issue", 64'(p_issue), 64'(0));
        check("reset_inflight", 64'(inflight), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(0));

        // Single request from requester 0
        tick();
        req_valid = 2'b01;
        req_d0 = '0; req_d1 = '0; req_d2 = '0;
        req_d0[W-1:0] = 34'h0_0040_0000;
        #3 check("single_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        check("single_issue", 64'(p_issue), 64'(1));
        check("single_p_d0", 64'(p_d0), 64'(34'h0_0040_0000));
        check("single_inflight_t1", 64'(inflight), 64'(1));
        repeat (5) tick();
        check("single_inflight_t6", 64'(inflight), 64'(1));
        check("single_no_rsp_t6", 64'(rsp_valid), 64'(0));
        tick();
        check("single_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        check("single_rsp_d0", 64'(rsp_d0), 64'(34'h0_0040_0001));
        check("single_inflight_t7", 64'(inflight), 64'(1));
        tick();
        check("single_inflight_t8", 64'(inflight), 64'(0));

        // Both requesters continuously valid from ptr=0
        do_reset();
        max_if = 0;
`ifdef CPLX_SCHED_SERIAL_EN
        for (int k = 0; k < 3 * (LAT + 1) + 1; k++) begin
            if (k > 0) tick();
            drive(2'b11);
            if (k % (LAT + 1) == 0) exp2 = ((k / (LAT + 1)) % 2 == 1) ? 2'b10 : 2'b01;
            else exp2 = 2'b00;
            #3 check("serial_grant", 64'(req_ready), 64'(exp2));
        end
        tick();
        req_valid = '0;
        repeat (LAT + 2) tick();
        check("serial_peak_le1", 64'(max_if <= 1), 64'(1));
`else
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            drive(2'b11);
            exp2 = (k % 2 == 1) ? 2'b10 : 2'b01;
            #3 check("rr_alternate", 64'(req_ready), 64'(exp2));
        end
        tick();
        req_valid = '0;
        repeat (LAT + 2) tick();
        check("rr_peak_inflight", 64'(max_if), 64'(LAT + 1));
`endif

        // Random request patterns: grant and return overlap frequently
        for (int k = 0; k < 40; k++) begin
            tick();
            drive(NREQ'($urandom_range(0, 3)));
        end
        tick();
        req_valid = '0;
        repeat (LAT + 2) tick();
        check("max_inflight_bound", 64'(max_if <= LAT + 1), 64'(1));

        // Reset with operations in flight
        do_reset();
        drive(2'b11);
        repeat (3) begin
            tick();
            drive(2'b11);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_p_issue", 64'(p_issue), 64'(0));
        check("midrst_p_d0", 64'(p_d0), 64'(0));
        check("midrst_inflight", 64'(inflight), 64'(0));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_rsp_d0", 64'(rsp_d0), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        repeat (LAT) tick();

        // Idle pipeline producing garbage
        force_val = 34'h3_FFFF_FFFF;
        force_en  = 1'b1;
        repeat (3) begin
            tick();
            check("idle_rsp_valid", 64'(rsp_valid), 64'(0));
            check("idle_rsp_d0", 64'(rsp_d0), 64'(0));
        end
        force_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/cplx_pipe_scheduler.md
# cplx_pipe_scheduler

Round-robin scheduler that shares one fixed-latency complex-arithmetic pipeline (three pdQp operand lanes d0/d1/d2 in, three pdQp result lanes out) between NREQ requesters. Sits between the per-channel operand sources and the shared pipeline. Grants at most one operand triple per cycle, zero-gates the pipeline inputs when idle, and tracks in-flight ownership tags so each result is routed back to the requester that issued it.

## Interface
- `pd`, 12, integer bits of pdQp operands
- `p`, 22, fractional bits; lane width W = pd+p
- `NREQ`, 2, number of requesters (2..4)
- `LAT`, 6, fixed pipeline latency in cycles, from `p_issue` to matching `p_r*` (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  requester i has a triple pending
- `req_ready`  out  NREQ  one-hot-or-zero grant; handshake when `req_valid[i] & req_ready[i]`
- `req_d0`, `req_d1`, `req_d2`  in  NREQ*W each  operand lanes; requester i occupies bits [i*W +: W]
- `p_issue`  out  1  operands on `p_d*` are valid this cycle
- `p_d0`, `p_d1`, `p_d2`  out  W each  registered operands to pipeline; all-zero when `p_issue`=0
- `p_r0`, `p_r1`, `p_r2`  in  W each  pipeline results
- `rsp_valid`  out  NREQ  one-hot-or-zero; result for requester i this cycle; no backpressure
- `rsp_d0`, `rsp_d1`, `rsp_d2`  out  W each  `p_r*` when any `rsp_valid`, else all-zero
- `inflight`  out  clog2(LAT+2)  operations issued but not yet returned
- `busy`  out  1  `inflight`≠0 or any `req_valid`

## Operation
- Arbitration: combinational, in cycle T. Search `req_valid` starting at round-robin pointer `ptr`, ascending with wrap. The first set bit gets `req_ready`.
- On a grant to i, `ptr` ← (i+1) mod NREQ. With no grant, `ptr` is unchanged.
- Eligibility (default): grants are allowed every cycle. `req_ready` does not depend on `req_valid` of other requesters beyond the priority search.
- Issue: at the edge ending cycle T, the granted triple is registered into `p_d*`, `p_issue` ← 1, and tag {valid=1, id=i} enters stage 0 of a LAT-deep tag shift register.
- With no grant: `p_issue` ← 0, `p_d*` ← 0, and an invalid tag enters the shift register.
- Return: the tag at stage LAT aligns with `p_r*`. If that tag is valid, `rsp_valid[id]`=1 and `rsp_d*`=`p_r*`, combinationally, for exactly one cycle.
- `inflight`: +1 on a grant, −1 on a valid tag return, unchanged when both happen in the same cycle. It never exceeds LAT+1 and never underflows.
- Pipeline results without a valid tag are ignored, and `rsp_d*` is held at zero.
- Reset: `ptr`=0, all tags invalid, `inflight`=0, `p_issue`=0, `p_d*`=0, so `req_ready`=0, `rsp_valid`=0 and `rsp_d*`=0 in the first cycle after reset.
  - While `rst`=1, `req_ready` is forced to 0.
  - Reset mid-operation discards all outstanding tags. Results the pipeline produces afterwards are never reported.

## Timing
- Handshake in cycle T → `p_issue`=1 in T+1 → `rsp_valid[i]`=1 in T+1+LAT. Request-to-response latency is LAT+1 cycles.
- Pipelined throughput: one issue per cycle, sustained.
- Simultaneous grant and return in one cycle are both honoured. A requester may be granted in the same cycle it receives a response.
- All state updates occur on the rising `clk`; `req_ready`, `rsp_valid`, `rsp_d*` and `busy` are combinational from registered state and inputs.

## Configuration
- `CPLX_SCHED_SERIAL_EN` defined: serial mode, with at most one operation in flight.
  - `req_ready` is all-zero unless `inflight`=0, or `inflight`=1 and a valid tag returns this cycle.
  - Back-to-back issues are therefore spaced exactly LAT+1 cycles apart.
  - Arbitration and `ptr` rules are unchanged.
- Undefined: fully pipelined as described above.

## Test plan
- Reset then a single request: `req_valid`=2'b01 with d0=34'h0_0040_0000, d1=0, d2=0 at T.
  - `req_ready`=2'b01 at T; `p_issue`=1 and `p_d0`=34'h0_0040_0000 at T+1.
  - `rsp_valid`=2'b01 at T+7 with `rsp_d0`=`p_r0`. `inflight` goes 1 from T+1 to T+7, then 0.
- Both requesters valid continuously for 8 cycles, ptr=0.
  - Grants alternate 01,10,01,… and `p_issue` stays high for 8 cycles.
  - Responses alternate in the same order, starting 7 cycles later. `inflight` peaks at 7.
- Grant and return in the same cycle (steady stream): `inflight` holds its value and is never observed above LAT+1=7.
- `rst` asserted 3 cycles after 4 issues.
  - All outputs are zero the next cycle.
  - No `rsp_valid` is seen for the discarded tags, even though the pipeline model drives nonzero `p_r*`.
- Idle pipeline, `p_r0`=34'h3_FFFF_FFFF with no tag: `rsp_valid`=0 and `rsp_d0`=0.
- With `CPLX_SCHED_SERIAL_EN`, both requesters continuously valid.
  - Grants occur at T, T+7, T+14, alternating 01,10,01.
  - `inflight`≤1 at all times.
